// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline sequencing controller: opcodes, special
// instruction words, controller states and source-usage decode.
package pipeline_hazard_controller_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] END_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StBrWait = 2'd1,
        StDrain  = 2'd2,
        StHalt   = 2'd3
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
               (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// RAW hazard detector: compares the sources actually read by the ID instruction
// against every in-flight destination. WB is included because the register
// file does not write through to a same-cycle read.
module pipeline_hazard_controller_hazard_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_reg_write_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_reg_write_i,
    output logic        hazard_o
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_instr;

    assign opcode = instr_i[6:0];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    // Remaining fields are irrelevant to dependency checking.
    assign unused_instr = ^{instr_i[31:25], instr_i[14:7]};

    // x0 is never a real dependency, which also keeps flushed NOPs hazard-free.
    always_comb begin
        rs1_hit = uses_rs1(opcode) && (rs1 != 5'd0) &&
                  ((ex_reg_write_i  && (rs1 == ex_rd_i))  ||
                   (mem_reg_write_i && (rs1 == mem_rd_i)) ||
                   (wb_reg_write_i  && (rs1 == wb_rd_i)));
        rs2_hit = uses_rs2(opcode) && (rs2 != 5'd0) &&
                  ((ex_reg_write_i  && (rs2 == ex_rd_i))  ||
                   (mem_reg_write_i && (rs2 == mem_rd_i)) ||
                   (wb_reg_write_i  && (rs2 == wb_rd_i)));
    end

    assign hazard_o = rs1_hit || rs2_hit;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing controller: stalls on RAW hazards, holds fetch while a
// branch resolves in MEM, drains and halts on the end-of-program sentinel, and
// keeps cycle / bubble / taken-branch counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      id_instr_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_reg_write_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_reg_write_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_reg_write_i,
    input  logic             mem_branch_i,
    input  logic             mem_zero_i,
    input  logic             if_end_i,
    output logic             pc_en_o,
    output logic             pc_sel_target_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam int unsigned DrainW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]  cycle_cnt_q, bubble_cnt_q, taken_cnt_q;
    logic              hazard;
    logic              bubble_inc;
    logic              taken_inc;

    pipeline_hazard_controller_hazard_detect u_hazard_detect (
        .instr_i         (id_instr_i),
        .ex_rd_i         (ex_rd_i),
        .ex_reg_write_i  (ex_reg_write_i),
        .mem_rd_i        (mem_rd_i),
        .mem_reg_write_i (mem_reg_write_i),
        .wb_rd_i         (wb_rd_i),
        .wb_reg_write_i  (wb_reg_write_i),
        .hazard_o        (hazard)
    );

    // Next-state and stage-control decode; reset forces free-running outputs.
    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        pc_en_o         = 1'b1;
        pc_sel_target_o = 1'b0;
        if_id_en_o      = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        halted_o        = 1'b0;
        taken_inc       = 1'b0;
        case (state_q)
            StRun: begin
                if (if_end_i) begin
                    pc_en_o = 1'b0;
                    state_d = StDrain;
                    drain_d = DrainW'(DRAIN_CYC - 1);
                end else if (hazard) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end else if (id_instr_i[6:0] == OP_BRANCH) begin
                    pc_en_o       = 1'b0;
                    if_id_flush_o = 1'b1;
                    state_d       = StBrWait;
                end
            end
            StBrWait: begin
                if (!mem_branch_i) begin
                    pc_en_o       = 1'b0;
                    if_id_flush_o = 1'b1;
                end else begin
                    state_d = StRun;
                    // Not taken: PC already sits at branch+4, so just let it load.
                    if (mem_zero_i) begin
                        pc_sel_target_o = 1'b1;
                        if_id_flush_o   = 1'b1;
                        taken_inc       = 1'b1;
                    end
                end
            end
            StDrain: begin
                pc_en_o = 1'b0;
                if (hazard) begin
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end else begin
                    if_id_flush_o = 1'b1;
                end
                if (drain_q <= DrainW'(1)) begin
                    drain_d = '0;
                    state_d = StHalt;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            StHalt: begin
                halted_o   = 1'b1;
                pc_en_o    = 1'b0;
                if_id_en_o = 1'b0;
            end
            default: state_d = StRun;
        endcase

        if (reset_i) begin
            pc_en_o         = 1'b1;
            pc_sel_target_o = 1'b0;
            if_id_en_o      = 1'b1;
            if_id_flush_o   = 1'b0;
            id_ex_flush_o   = 1'b0;
            halted_o        = 1'b0;
            taken_inc       = 1'b0;
        end

        // Drain-phase stalls are not counted as bubbles.
        bubble_inc = ((state_q == StRun) || (state_q == StBrWait)) &&
                     (if_id_flush_o || id_ex_flush_o);
    end

    // State, drain counter and performance counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StRun;
            drain_q      <= '0;
            cycle_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (state_q != StHalt) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (bubble_inc) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
            if (taken_inc) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt_o  = cycle_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign taken_cnt_o  = taken_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. The pipeline stage contents
// are driven by hand each cycle; control outputs are compared as one vector
// ctl = {pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_flush, halted}.
module tb_pipeline_hazard_controller;

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD_X2_X1  = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] I_ADD_X2_X0  = 32'h0000_0133; // add  x2,x0,x0
    localparam logic [31:0] I_BEQ_X0_X0  = 32'h0000_0463; // beq  x0,x0,+8
    localparam logic [31:0] I_BEQ_X0_X1  = 32'h0010_0463; // beq  x0,x1,+8
    localparam logic [31:0] I_SW_RS2_X5  = 32'h0050_0023; // sw   x5,0(x0)
    localparam logic [31:0] I_LUI_RS1F1  = 32'h0000_80B7; // lui  x1 (rs1 field = 1)
    localparam logic [31:0] I_ADDI_IMM2  = 32'h0020_0193; // addi x3,x0,2 (rs2 field = 2)
    localparam logic [31:0] I_NOP        = 32'h0000_0013;

    localparam logic [5:0] C_RUN    = 6'b101000;
    localparam logic [5:0] C_STALL  = 6'b000010;
    localparam logic [5:0] C_END    = 6'b001000;
    localparam logic [5:0] C_HOLD   = 6'b001100;
    localparam logic [5:0] C_TAKEN  = 6'b111100;
    localparam logic [5:0] C_HALT   = 6'b000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_rw, mem_rw, wb_rw;
    logic        mem_branch, mem_zero, if_end;
    logic        pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [31:0] cycle_cnt, bubble_cnt, taken_cnt;
    logic [5:0]  ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_flush, halted};

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .CNT_W     (32),
        .DRAIN_CYC (4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .id_instr_i      (id_instr),
        .ex_rd_i         (ex_rd),
        .ex_reg_write_i  (ex_rw),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_rw),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_rw),
        .mem_branch_i    (mem_branch),
        .mem_zero_i      (mem_zero),
        .if_end_i        (if_end),
        .pc_en_o         (pc_en),
        .pc_sel_target_o (pc_sel_target),
        .if_id_en_o      (if_id_en),
        .if_id_flush_o   (if_id_flush),
        .id_ex_flush_o   (id_ex_flush),
        .halted_o        (halted),
        .cycle_cnt_o     (cycle_cnt),
        .bubble_cnt_o    (bubble_cnt),
        .taken_cnt_o     (taken_cnt)
    );

    // Drive one cycle's pipeline contents, then let combinational outputs settle.
    task automatic drive(input logic [31:0] instr,
                         input logic [4:0] erd, input logic erw,
                         input logic [4:0] mrd, input logic mrw,
                         input logic [4:0] wrd, input logic wrw,
                         input logic mb, input logic mz, input logic fin);
        id_instr   = instr;
        ex_rd      = erd;  ex_rw  = erw;
        mem_rd     = mrd;  mem_rw = mrw;
        wb_rd      = wrd;  wb_rw  = wrw;
        mem_branch = mb;   mem_zero = mz;
        if_end     = fin;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(I_ADD_X2_X1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL reset_outputs: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        reset = 1'b0;
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({cycle_cnt, bubble_cnt, taken_cnt} !== 96'd0) begin
            errors++; $display("FAIL reset_counters: cyc=%0d bub=%0d tkn=%0d expected 0 0 0",
                               cycle_cnt, bubble_cnt, taken_cnt);
        end
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL reset_run: ctl=%b expected %b", ctl, C_RUN);
        end
    endtask

    // addi x1 ahead of add x2,x1,x1: three stall cycles (EX, MEM, WB).
    task automatic test_raw_stall();
        do_reset();
        drive(I_ADD_X2_X1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL raw_ex: ctl=%b expected %b", ctl, C_STALL);
        end
        step();
        drive(I_ADD_X2_X1, 5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL raw_mem: ctl=%b expected %b", ctl, C_STALL);
        end
        step();
        drive(I_ADD_X2_X1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL raw_wb: ctl=%b expected %b", ctl, C_STALL);
        end
        step();
        drive(I_ADD_X2_X1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL raw_clear: ctl=%b expected %b", ctl, C_RUN);
        end
        checks++;
        if (bubble_cnt !== 32'd3 || cycle_cnt !== 32'd3) begin
            errors++; $display("FAIL raw_counts: bub=%0d cyc=%0d expected 3 3",
                               bubble_cnt, cycle_cnt);
        end
        step();
    endtask

    // Matches that must not stall: x0, reg_write low, unused source fields.
    task automatic test_no_hazard();
        do_reset();
        drive(I_ADD_X2_X0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL nohaz_x0: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        drive(I_ADD_X2_X1, 5'd1, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL nohaz_rw0: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        drive(I_LUI_RS1F1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL nohaz_lui: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        drive(I_ADDI_IMM2, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL nohaz_itype_rs2: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        drive(I_SW_RS2_X5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL haz_store_rs2: ctl=%b expected %b", ctl, C_STALL);
        end
        drive(I_ADDI_X1_5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bubble_cnt !== 32'd0) begin
            errors++; $display("FAIL nohaz_bubbles: bub=%0d expected 0", bubble_cnt);
        end
        step();
    endtask

    // beq x0,x0 taken: two held cycles, then redirect; if_end ignored meanwhile.
    task automatic test_branch_taken();
        do_reset();
        drive(I_BEQ_X0_X0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL bt_id: ctl=%b expected %b", ctl, C_HOLD);
        end
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL bt_wait: ctl=%b expected %b", ctl, C_HOLD);
        end
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_TAKEN) begin
            errors++; $display("FAIL bt_resolve: ctl=%b expected %b", ctl, C_TAKEN);
        end
        step();
        drive(I_ADD_X2_X0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL bt_after: ctl=%b expected %b", ctl, C_RUN);
        end
        checks++;
        if (taken_cnt !== 32'd1 || bubble_cnt !== 32'd3 || cycle_cnt !== 32'd3) begin
            errors++; $display("FAIL bt_counts: tkn=%0d bub=%0d cyc=%0d expected 1 3 3",
                               taken_cnt, bubble_cnt, cycle_cnt);
        end
        step();
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        drive(I_BEQ_X0_X1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL bnt_id: ctl=%b expected %b", ctl, C_HOLD);
        end
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL bnt_resolve: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        drive(I_ADD_X2_X0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL bnt_after: ctl=%b expected %b", ctl, C_RUN);
        end
        checks++;
        if (taken_cnt !== 32'd0 || bubble_cnt !== 32'd2) begin
            errors++; $display("FAIL bnt_counts: tkn=%0d bub=%0d expected 0 2",
                               taken_cnt, bubble_cnt);
        end
        step();
    endtask

    // Sentinel at cycle t: drain with a hazard stall at t+2, halted at t+4.
    task automatic test_drain_halt();
        do_reset();
        drive(I_ADD_X2_X0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctl !== C_END) begin
            errors++; $display("FAIL dr_sentinel: ctl=%b expected %b", ctl, C_END);
        end
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL dr_t1: ctl=%b expected %b", ctl, C_HOLD);
        end
        step();
        drive(I_ADD_X2_X1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL dr_t2_stall: ctl=%b expected %b", ctl, C_STALL);
        end
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL dr_t3: ctl=%b expected %b", ctl, C_HOLD);
        end
        step();
        checks++;
        if (ctl !== C_HALT) begin
            errors++; $display("FAIL dr_t4_halt: ctl=%b expected %b", ctl, C_HALT);
        end
        for (int i = 0; i < 3; i++) begin
            drive(I_ADD_X2_X1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            step();
        end
        checks++;
        if (ctl !== C_HALT) begin
            errors++; $display("FAIL dr_halt_hold: ctl=%b expected %b", ctl, C_HALT);
        end
        checks++;
        if (cycle_cnt !== 32'd4 || bubble_cnt !== 32'd0 || taken_cnt !== 32'd0) begin
            errors++; $display("FAIL dr_counts: cyc=%0d bub=%0d tkn=%0d expected 4 0 0",
                               cycle_cnt, bubble_cnt, taken_cnt);
        end
    endtask

    // Reset while waiting on a branch must drop the pending branch entirely.
    task automatic test_reset_mid_branch();
        do_reset();
        drive(I_BEQ_X0_X0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bubble_cnt !== 32'd2) begin
            errors++; $display("FAIL rb_pre_bubbles: bub=%0d expected 2", bubble_cnt);
        end
        reset = 1'b1;
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL rb_during: ctl=%b expected %b", ctl, C_RUN);
        end
        step();
        reset = 1'b0;
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL rb_after: ctl=%b expected %b", ctl, C_RUN);
        end
        checks++;
        if ({cycle_cnt, bubble_cnt, taken_cnt} !== 96'd0) begin
            errors++; $display("FAIL rb_counters: cyc=%0d bub=%0d tkn=%0d expected 0 0 0",
                               cycle_cnt, bubble_cnt, taken_cnt);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(I_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        test_reset();
        test_raw_stall();
        test_no_hazard();
        test_branch_taken();
        test_branch_not_taken();
        test_drain_halt();
        test_reset_mid_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
